// File: rtl/mem_stage_sb.sv
`default_nettype none
// mem_stage_sb -- RV32I memory stage: in-order store buffer, load bypass and store-to-load forwarding (rev 1.0)
module mem_stage_sb #(
  parameter int DEPTH  = 4,
  parameter int FWD_EN = 1,
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [2:0]        mem_len,
  input  logic              mem_done,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] LD_BUSY = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic [1:0]        state;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [XLEN-1:0]   buf_data [DEPTH];
  logic [2:0]        buf_len  [DEPTH];

  logic              is_load;
  logic              is_store;
  logic [2:0]        op_len;
  logic [XLEN-1:0]   store_data;
  logic              any_conf;
  logic [PW-1:0]     young_idx;
  logic [PW-1:0]     scan_idx;
  logic              fwd_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic              ld_issue;

  function automatic logic [XLEN-1:0] load_ext(input logic [3:0] op, input logic [XLEN-1:0] d);
    case (op)
      OP_LB:   load_ext = {{(XLEN-8){d[7]}}, d[7:0]};
      OP_LH:   load_ext = {{(XLEN-16){d[15]}}, d[15:0]};
      OP_LBU:  load_ext = {{(XLEN-8){1'b0}}, d[7:0]};
      OP_LHU:  load_ext = {{(XLEN-16){1'b0}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_len   = 3'd4;
    case (in_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; op_len = 3'd1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; op_len = 3'd2; end
      OP_LW:         begin is_load  = 1'b1; op_len = 3'd4; end
      OP_SB:         begin is_store = 1'b1; op_len = 3'd1; end
      OP_SH:         begin is_store = 1'b1; op_len = 3'd2; end
      OP_SW:         begin is_store = 1'b1; op_len = 3'd4; end
      default: ;
    endcase
  end

  always_comb begin
    case (op_len)
      3'd1:    store_data = XLEN'(in_data[7:0]);
      3'd2:    store_data = XLEN'(in_data[15:0]);
      default: store_data = in_data;
    endcase
  end

  // Scan oldest to youngest so the last hit is the youngest conflicting entry.
  always_comb begin
    any_conf  = 1'b0;
    young_idx = head;
    scan_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (i < int'(count) && buf_addr[scan_idx][ADDR_W-1:2] == in_addr[ADDR_W-1:2]) begin
        any_conf  = 1'b1;
        young_idx = scan_idx;
      end
    end
  end

  assign fwd_ok = (FWD_EN != 0) && any_conf && is_load &&
                  (buf_addr[young_idx] == in_addr) && (buf_len[young_idx] == op_len);

  always_comb begin
    stall_out = 1'b0;
    if (!rdy_in) begin
      stall_out = 1'b1;
    end else if (in_valid) begin
      if (is_store)
        stall_out = (count == FULL);
      else if (is_load && !fwd_ok)
        stall_out = any_conf || !(state == LD_BUSY && mem_done);
    end
  end

  assign accept   = rdy_in && in_valid && !stall_out;
  assign push     = accept && is_store;
  assign pop      = rdy_in && (state == ST_BUSY) && mem_done;
  assign ld_issue = in_valid && is_load && !any_conf;

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && push) begin
      buf_addr[tail] <= in_addr;
      buf_data[tail] <= store_data;
      buf_len[tail]  <= op_len;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_len   <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else if (rdy_in) begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);

      case (state)
        IDLE: begin
          if (ld_issue) begin
            state     <= LD_BUSY;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= in_addr;
            mem_wdata <= '0;
            mem_len   <= op_len;
          end else if (count != '0) begin
            state     <= ST_BUSY;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= buf_addr[head];
            mem_wdata <= buf_data[head];
            mem_len   <= buf_len[head];
          end
        end
        ST_BUSY, LD_BUSY: begin
          if (mem_done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // An accepted non-forwarded load can only be the one completing in LD_BUSY.
      wb_valid <= 1'b0;
      if (accept && !is_store) begin
        wb_valid <= 1'b1;
        wb_rd    <= in_rd;
        if (!is_load)
          wb_data <= in_data;
        else if (fwd_ok)
          wb_data <= load_ext(in_op, buf_data[young_idx]);
        else
          wb_data <= load_ext(in_op, mem_rdata);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sb.sv
`default_nettype none
// tb_mem_stage_sb -- directed self-checking bench for mem_stage_sb (DEPTH=4, FWD_EN=1)
module tb_mem_stage_sb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic        stall_out;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_len;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_stage_sb #(.DEPTH(4), .FWD_EN(1), .ADDR_W(32), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd), .in_data(in_data), .in_addr(in_addr),
    .stall_out(stall_out),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] a);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_data  = d;
    in_addr  = a;
  endtask

  task automatic drop();
    in_valid = 1'b0;
    in_op    = 4'd0;
    in_rd    = 5'd0;
    in_data  = 32'd0;
    in_addr  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    mem_done  = 1'b0;
    mem_rdata = 32'd0;
    drop();
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_stall", stall_out, 0);
    rst_in = 1'b1;
    tick();

    // PASS
    put(4'd0, 5'd5, 32'h1234, 32'h0);
    #1 check("pass_stall", stall_out, 0);
    tick();
    check("pass_wb_valid", wb_valid, 1);
    check("pass_wb_rd", wb_rd, 5);
    check("pass_wb_data", wb_data, 32'h1234);
    drop();
    tick();
    check("pass_wb_drop", wb_valid, 0);

    // SW then LW same address: forwarded
    put(4'd8, 5'd0, 32'hDEADBEEF, 32'h100);
    #1 check("sw_stall", stall_out, 0);
    tick();
    check("sw_no_wb", wb_valid, 0);
    put(4'd3, 5'd7, 32'h0, 32'h100);
    #1 check("fwd_stall", stall_out, 0);
    tick();
    check("fwd_wb_valid", wb_valid, 1);
    check("fwd_wb_rd", wb_rd, 7);
    check("fwd_wb_data", wb_data, 32'hDEADBEEF);
    check("fwd_req_is_store", mem_wr, 1);
    check("fwd_st_req", mem_req, 1);
    check("fwd_st_addr", mem_addr, 32'h100);
    check("fwd_st_len", mem_len, 4);
    check("fwd_st_wdata", mem_wdata, 32'hDEADBEEF);
    drop();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("fwd_st_req_drop", mem_req, 0);
    tick();
    check("fwd_idle", mem_req, 0);

    // SB@0x103 then LB@0x100: partial conflict waits for drain
    put(4'd6, 5'd0, 32'h80, 32'h103);
    tick();
    put(4'd1, 5'd9, 32'h0, 32'h100);
    #1 check("conf_stall0", stall_out, 1);
    tick();
    check("conf_st_req", mem_req, 1);
    check("conf_st_wr", mem_wr, 1);
    check("conf_st_addr", mem_addr, 32'h103);
    check("conf_st_len", mem_len, 1);
    check("conf_st_wdata", mem_wdata, 32'h80);
    check("conf_stall1", stall_out, 1);
    mem_done = 1'b1;
    #1 check("conf_stall_done", stall_out, 1);
    tick();
    mem_done = 1'b0;
    check("conf_gap", mem_req, 0);
    check("conf_stall2", stall_out, 1);
    tick();
    check("conf_ld_req", mem_req, 1);
    check("conf_ld_wr", mem_wr, 0);
    check("conf_ld_addr", mem_addr, 32'h100);
    check("conf_ld_len", mem_len, 1);
    mem_done  = 1'b1;
    mem_rdata = 32'h80FFFFFF;
    #1 check("conf_ld_accept", stall_out, 0);
    tick();
    mem_done = 1'b0;
    drop();
    check("conf_wb_valid", wb_valid, 1);
    check("conf_wb_rd", wb_rd, 9);
    check("conf_wb_data", wb_data, 32'hFFFFFFFF);
    check("conf_ld_req_drop", mem_req, 0);
    tick();

    // Five SWs into a 4-deep buffer
    put(4'd8, 5'd0, 32'h11, 32'h400);
    tick();
    put(4'd8, 5'd0, 32'h22, 32'h404);
    tick();
    check("full_head_req", mem_req, 1);
    check("full_head_addr", mem_addr, 32'h400);
    put(4'd8, 5'd0, 32'h33, 32'h408);
    tick();
    put(4'd8, 5'd0, 32'h44, 32'h40C);
    tick();
    put(4'd8, 5'd0, 32'h55, 32'h410);
    #1 check("full_stall0", stall_out, 1);
    tick();
    check("full_stall1", stall_out, 1);
    mem_done = 1'b1;
    #1 check("full_no_bypass", stall_out, 1);
    tick();
    mem_done = 1'b0;
    check("full_pop_gap", mem_req, 0);
    check("full_accept", stall_out, 0);
    tick();
    drop();
    for (int k = 1; k <= 4; k++) begin
      check("drain_req", mem_req, 1);
      check("drain_addr", mem_addr, 32'h400 + 32'(4 * k));
      check("drain_wdata", mem_wdata, 32'(17 * (k + 1)));
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      tick();
    end
    check("drain_empty", mem_req, 0);

    // Non-conflicting LHU overtakes a queued SW
    put(4'd8, 5'd0, 32'hAAAA, 32'h200);
    tick();
    put(4'd5, 5'd3, 32'h0, 32'h300);
    #1 check("byp_stall", stall_out, 1);
    tick();
    check("byp_ld_req", mem_req, 1);
    check("byp_ld_wr", mem_wr, 0);
    check("byp_ld_addr", mem_addr, 32'h300);
    check("byp_ld_len", mem_len, 2);
    mem_done  = 1'b1;
    mem_rdata = 32'h0000F00D;
    #1 check("byp_accept", stall_out, 0);
    tick();
    mem_done = 1'b0;
    drop();
    check("byp_wb_valid", wb_valid, 1);
    check("byp_wb_rd", wb_rd, 3);
    check("byp_wb_data", wb_data, 32'h0000F00D);
    tick();
    check("byp_st_req", mem_req, 1);
    check("byp_st_wr", mem_wr, 1);
    check("byp_st_addr", mem_addr, 32'h200);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();

    // SB forwarding into LB: masked store data, sign-extended load
    put(4'd6, 5'd0, 32'h123456F0, 32'h700);
    tick();
    put(4'd1, 5'd2, 32'h0, 32'h700);
    #1 check("fwdb_stall", stall_out, 0);
    tick();
    drop();
    check("fwdb_wb_data", wb_data, 32'hFFFFFFF0);
    check("fwdb_st_wdata", mem_wdata, 32'h000000F0);
    check("fwdb_st_len", mem_len, 1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();

    // Reset during LD_BUSY with two stores buffered
    put(4'd8, 5'd0, 32'h1, 32'h500);
    tick();
    put(4'd8, 5'd0, 32'h2, 32'h504);
    tick();
    put(4'd8, 5'd0, 32'h3, 32'h508);
    tick();
    put(4'd3, 5'd4, 32'h0, 32'h600);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    check("rstm_ld_req", mem_req, 1);
    check("rstm_ld_wr", mem_wr, 0);
    check("rstm_ld_addr", mem_addr, 32'h600);
    rst_in = 1'b0;
    drop();
    tick();
    check("rstm_req", mem_req, 0);
    check("rstm_wb", wb_valid, 0);
    rst_in    = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_done = 1'b0;
    check("rstm_late_wb", wb_valid, 0);
    check("rstm_late_req", mem_req, 0);
    tick();
    check("rstm_discard", mem_req, 0);
    tick();
    check("rstm_discard2", mem_req, 0);

    // rdy_in low freezes and stalls
    put(4'd0, 5'd6, 32'h77, 32'h0);
    rdy_in = 1'b0;
    #1 check("rdy_stall", stall_out, 1);
    tick();
    check("rdy_frozen_wb", wb_valid, 0);
    rdy_in = 1'b1;
    #1 check("rdy_release", stall_out, 0);
    tick();
    drop();
    check("rdy_wb_valid", wb_valid, 1);
    check("rdy_wb_data", wb_data, 32'h77);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
